// File: rtl/node_arbiter.sv
// ----------------------------------------------------------------------------
// node_arbiter
//   Four-input round-robin arbiter that issues a selection token to a merge
//   stage, waits for the merged packet to complete downstream, and aborts
//   with an error pulse if completion does not arrive in time.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module node_arbiter #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CTRL_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  output logic [CTRL_W-1:0] ctrl_data,
  output logic              ctrl_valid,
  input  logic              ctrl_ready,
  input  logic              xfer_done,
  output logic [3:0]        grant,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_spurious
);

  // Counter must be able to hold TIMEOUT_CYC itself (it saturates there).
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       winner;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick;
  logic             tmo_hit;

  // Round-robin pick: scan from ptr upward; walking offsets high-to-low lets
  // the lowest matching offset overwrite the result last.
  always_comb begin
    pick = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        pick = ptr + 2'(i);
      end
    end
  end

  // Timeout fires on the WAIT edge that would bring the count up to the limit.
  always_comb begin
    tmo_hit = (TIMEOUT_CYC != 0) && ((int'(cnt) + 1) >= TIMEOUT_CYC);
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ptr          <= 2'd0;
      winner       <= 2'd0;
      cnt          <= '0;
      ctrl_data    <= '0;
      ctrl_valid   <= 1'b0;
      grant        <= 4'b0000;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      err_timeout  <= 1'b0;
      // Completion is only meaningful while waiting for it.
      err_spurious <= xfer_done && (state != S_WAIT);
      case (state)
        S_IDLE: begin
          if (|req) begin
            winner     <= pick;
            ctrl_data  <= CTRL_W'(pick);
            grant      <= 4'b0001 << pick;
            ctrl_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= S_OFFER;
          end
        end
        S_OFFER: begin
          // Token stays committed regardless of req until the merge accepts.
          if (ctrl_ready) begin
            ctrl_valid <= 1'b0;
            cnt        <= '0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (xfer_done) begin
            ptr   <= winner + 2'd1;
            grant <= 4'b0000;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (tmo_hit) begin
            err_timeout <= 1'b1;
            ptr         <= winner + 2'd1;
            grant       <= 4'b0000;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else if (int'(cnt) < TIMEOUT_CYC) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_node_arbiter.sv
// ----------------------------------------------------------------------------
// tb_node_arbiter
//   Directed scenarios plus randomized traffic against a transaction-level
//   reference model of the arbiter.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_node_arbiter;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [2:0] ctrl_data;
  logic       ctrl_valid;
  logic       ctrl_ready;
  logic       xfer_done;
  logic [3:0] grant;
  logic       busy;
  logic       err_timeout;
  logic       err_spurious;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int tok_q[$];

  node_arbiter #(.TIMEOUT_CYC(TMO), .CTRL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .ctrl_data(ctrl_data), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .xfer_done(xfer_done), .grant(grant), .busy(busy),
    .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = no arbitration in flight, 1 = token offered,
  // 2 = token accepted and awaiting completion; wait_cycles counts WAIT time.
  int m_phase = 0;
  int m_next  = 0;
  int m_win   = 0;
  int m_wait  = 0;
  bit m_terr  = 0;
  bit m_serr  = 0;

  function automatic int rr_pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_next = 0; m_win = 0; m_wait = 0; m_terr = 0; m_serr = 0;
    end else begin
      m_terr = 0;
      m_serr = (xfer_done === 1'b1) && (m_phase != 2);
      if (m_phase == 0) begin
        if (req != 4'b0) begin
          m_win   = rr_pick(req, m_next);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (ctrl_ready) begin
          m_phase = 2;
          m_wait  = 0;
        end
      end else begin
        if (xfer_done) begin
          m_next  = (m_win + 1) % 4;
          m_phase = 0;
        end else begin
          m_wait = m_wait + 1;
          if (TMO != 0 && m_wait >= TMO) begin
            m_terr  = 1;
            m_next  = (m_win + 1) % 4;
            m_phase = 0;
          end
        end
      end
    end
  end

  // Log each accepted token as seen on the DUT's own outputs.
  always @(posedge clk) begin
    if (rst_n && ctrl_valid && ctrl_ready) tok_q.push_back(int'(ctrl_data));
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] act, exp;
      exp = {20'd0,
             (m_phase == 1) ? 3'(m_win) : 3'd0,
             (m_phase != 0) ? (4'b0001 << m_win) : 4'b0000,
             (m_phase == 1), (m_phase != 0), m_terr, m_serr};
      act = {20'd0,
             (m_phase == 1) ? ctrl_data : 3'd0,
             grant, ctrl_valid, busy, err_timeout, err_spurious};
      chk("cycle_outputs", act, exp);
    end
  end

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    tok_q.delete();
  endtask

  task automatic wait_tok(output bit ok);
    int s;
    s  = tok_q.size();
    ok = 1'b0;
    for (int g = 0; g < 60; g++) begin
      @(negedge clk); #1;
      if (tok_q.size() > s) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("token_wait_bound", 32'd0, 32'd1);
  endtask

  task automatic pulse_done(input int dly);
    repeat (dly - 1) @(negedge clk);
    #1 xfer_done = 1'b1;
    @(negedge clk);
    #1 xfer_done = 1'b0;
  endtask

  initial begin
    bit ok;
    int idx;
    int cnt;
    int exp_a[4] = '{0, 2, 0, 2};
    int exp_b[5] = '{0, 1, 2, 3, 0};

    rst_n = 1'b0; req = 4'b0; ctrl_ready = 1'b0; xfer_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {ctrl_data, grant, ctrl_valid, busy, err_timeout, err_spurious}, 32'd0);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Alternating pair of requesters.
    do_reset();
    req = 4'b0101; ctrl_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_tok(ok);
      if (ok) pulse_done(2);
    end
    chk("rr_pair_count", tok_q.size(), 4);
    for (int t = 0; t < 4 && t < tok_q.size(); t++) chk("rr_pair_token", tok_q[t], exp_a[t]);

    // All four requesting: full rotation and wrap.
    do_reset();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_tok(ok);
      if (ok) pulse_done(2);
    end
    chk("rr_all_count", tok_q.size(), 5);
    for (int t = 0; t < 5 && t < tok_q.size(); t++) chk("rr_all_token", tok_q[t], exp_b[t]);

    // Backpressure: one-cycle request, token held through 5 stalled cycles.
    do_reset();
    req = 4'b0000; ctrl_ready = 1'b0;
    @(negedge clk); #1 req = 4'b0010;
    @(negedge clk); #1 req = 4'b0000;
    cnt = 0;
    for (int t = 0; t < 5; t++) begin
      if (ctrl_valid && ctrl_data == 3'b001) cnt++;
      @(negedge clk); #1;
    end
    chk("stall_valid_cycles", cnt, 5);
    ctrl_ready = 1'b1;
    wait_tok(ok);
    chk("stall_token", ok ? tok_q[$] : -1, 1);

    // Timeout: no completion after acceptance.
    req = 4'b0001;
    wait_tok(ok);
    req = 4'b0000;
    idx = -1;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk); #1;
      if (err_timeout && idx < 0) idx = t;
    end
    chk("timeout_delay", idx, 4);
    req = 4'b0011;
    wait_tok(ok);
    chk("post_timeout_winner", ok ? tok_q[$] : -1, 1);
    pulse_done(2);

    // Completion coincident with the timeout edge: completion wins.
    req = 4'b0001;
    wait_tok(ok);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    #1 xfer_done = 1'b1;
    @(negedge clk); #1 xfer_done = 1'b0;
    cnt = (err_timeout === 1'b1) ? 1 : 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (err_timeout) cnt++;
    end
    chk("coincident_no_timeout", cnt, 0);

    // Completion while idle is flagged and ignored.
    @(negedge clk); #1 xfer_done = 1'b1;
    @(negedge clk); #1 xfer_done = 1'b0;
    chk("spurious_flag", {err_spurious, busy}, 2'b10);

    // Asynchronous reset during WAIT, then restart from index 0.
    req = 4'b1000;
    wait_tok(ok);
    chk("wait_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_clear", {ctrl_data, grant, ctrl_valid, busy, err_timeout, err_spurious}, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    req = 4'b1111;
    tok_q.delete();
    wait_tok(ok);
    chk("restart_from_zero", ok ? tok_q[0] : -1, 0);
    pulse_done(2);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      case ($urandom_range(0, 3))
        0: req = 4'($urandom);
        1: req = 4'b0001 << $urandom_range(0, 3);
        2: req = 4'b1111;
        default: req = req;
      endcase
      ctrl_ready = ($urandom_range(0, 2) != 0);
      xfer_done  = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk); #1;
    rst_n = 1'b1; req = 4'b0; xfer_done = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/node_arbiter.md
NODE_ARBITER -- requirements
Module: node_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, sets the cycles allowed from token acceptance to xfer_done; 0 disables the timeout.
REQ-002 Parameter CTRL_W, default 3, is the control token width; the value is fixed at 3 for the 4-input merge stage.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  4  level request per merge input i, high while input i holds a packet for this output.
REQ-006 ctrl_data  output  CTRL_W  selection token to the merge stage: 3'b000..3'b011 select inputs 0..3.
REQ-007 ctrl_valid  output  1  token offered.
REQ-008 ctrl_ready  input  1  merge stage accepts the token; a transfer is ctrl_valid & ctrl_ready on a rising edge.
REQ-009 xfer_done  input  1  single-cycle pulse when the merge output packet has been accepted downstream.
REQ-010 grant  output  4  one-hot copy of the current winner, valid in OFFER and WAIT.
REQ-011 busy  output  1  high in OFFER or WAIT.
REQ-012 err_timeout  output  1  single-cycle pulse on timeout abort.
REQ-013 err_spurious  output  1  single-cycle pulse when xfer_done arrives outside WAIT.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, OFFER and WAIT.
REQ-015 IDLE: if any req bit is high at an edge, the block registers the winner, loads ctrl_data = {1'b0, winner[1:0]} and grant, and enters OFFER; otherwise it stays in IDLE.
REQ-016 Winner selection: round-robin, searching req from index ptr upward modulo 4; the first set bit wins.
REQ-017 Latency: req sampled high in IDLE at edge k SHALL give ctrl_valid = 1 immediately after edge k.
REQ-018 OFFER: ctrl_valid = 1 and ctrl_data/grant held stable until a transfer; on transfer the block enters WAIT and clears the timeout counter.
REQ-019 A committed token is never retracted: deassertion of req during OFFER SHALL not change ctrl_data or leave OFFER.
REQ-020 WAIT: ctrl_valid = 0 and grant held; on xfer_done, ptr <= (winner + 1) mod 4 and the block returns to IDLE.
REQ-021 Back-to-back arbitrations SHALL be separated by one IDLE cycle.
REQ-022 Timeout counter: increments each WAIT cycle without xfer_done and saturates at TIMEOUT_CYC.
REQ-023 When the count reaches TIMEOUT_CYC (TIMEOUT_CYC != 0), the block pulses err_timeout, advances ptr past the winner, and returns to IDLE.
REQ-024 If xfer_done and the timeout fire in the same cycle, xfer_done wins and err_timeout stays low.
REQ-025 xfer_done in IDLE or OFFER SHALL be ignored for state and pulse err_spurious.
REQ-026 Pointer wrap: ptr is 2 bits and 3 + 1 wraps to 0.
REQ-027 A single requester holding req continuously SHALL be re-granted every arbitration; no request starves beyond 3 intervening grants.

Reset
REQ-028 rst_n low SHALL immediately force state = IDLE, ptr = 0, ctrl_valid = 0, ctrl_data = 3'b000, grant = 4'b0000, busy = 0, err_timeout = 0, err_spurious = 0, timeout counter = 0.
REQ-029 Reset asserted mid-OFFER or mid-WAIT SHALL abandon the token with no error pulse.
REQ-030 Operation resumes on the first rising edge after rst_n rises.

Verification
REQ-031 Reset, then req = 4'b0101, hold ctrl_ready = 1, pulse xfer_done 2 cycles after each token accepted: ctrl_data sequence 000, 010, 000, 010; grant 0001/0100 alternating.
REQ-032 req = 4'b1111 held: tokens 000, 001, 010, 011, 000; each separated by exactly one IDLE cycle after xfer_done.
REQ-033 req = 4'b0010 for 1 cycle, ctrl_ready low 5 cycles: ctrl_valid high 5 cycles with ctrl_data = 001 stable; accepted on 6th.
REQ-034 TIMEOUT_CYC = 4, token accepted, no xfer_done: err_timeout pulses 4 cycles after acceptance, state IDLE, next winner is index after previous.
REQ-035 xfer_done pulsed in IDLE: err_spurious pulses, no state change; xfer_done coincident with timeout: no err_timeout.
REQ-036 rst_n dropped during WAIT: all outputs clear asynchronously before the next edge; after release, the first grant starts from index 0.
